// File: rtl/preview_box_mapper.sv
// Pixel mapper for one preview box: flags grid-line and occupied-cell pixels, 1-cycle latency.
// Define PREVIEW_DOUBLE_BUFFER_EN to stage loads in a shadow buffer that commits on frame_sync.
module preview_box_mapper #(
    parameter int X0           = 140,
    parameter int Y0           = 100,
    parameter int CELL         = 20,
    parameter int COLS         = 4,
    parameter int ROWS         = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 frame_sync,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ROWS*COLS-1:0] shape_in,
    input  logic [3:0]           color_in,
    input  logic                 blink_en,
    output logic                 is_grid,
    output logic                 is_block,
    output logic [3:0]           block_color
);

    localparam int NCELL = ROWS * COLS;
    localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [9:0]       BOX_W    = 10'(COLS * CELL);
    localparam logic [9:0]       BOX_H    = 10'(ROWS * CELL);
    localparam logic [9:0]       CELL_PX  = 10'(CELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [NCELL-1:0] active_shape_q, active_shape_d;
    logic [3:0]       active_color_q, active_color_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             is_grid_q, is_grid_d;
    logic             is_block_q, is_block_d;
    logic [3:0]       block_color_q, block_color_d;

    // Bit 10 of the offsets is the sign: left of / above the box.
    logic [10:0]      dx, dy;
    logic [9:0]       col_idx, row_idx;
    logic [IDX_W-1:0] cell_idx;
    logic             in_box, on_line, interior;

    assign dx       = {1'b0, DrawX} - 11'(X0);
    assign dy       = {1'b0, DrawY} - 11'(Y0);
    assign in_box   = ~dx[10] & ~dy[10] & (dx[9:0] <= BOX_W) & (dy[9:0] <= BOX_H);
    assign on_line  = ((dx[9:0] % CELL_PX) == '0) | ((dy[9:0] % CELL_PX) == '0);
    assign interior = in_box & ~on_line;
    assign col_idx  = dx[9:0] / CELL_PX;
    assign row_idx  = dy[9:0] / CELL_PX;
    assign cell_idx = IDX_W'(row_idx * 10'(COLS) + col_idx);

`ifdef PREVIEW_DOUBLE_BUFFER_EN
    logic [NCELL-1:0] pend_shape_q, pend_shape_d;
    logic [3:0]       pend_color_q, pend_color_d;
    logic             pend_full_q, pend_full_d;

    assign load_ready = ~pend_full_q;
`else
    assign load_ready = 1'b1;
`endif

    always_comb begin
        // NOTE: every _d takes its held value first, so no path leaves it unassigned (no latch).
        active_shape_d = active_shape_q;
        active_color_d = active_color_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
`ifdef PREVIEW_DOUBLE_BUFFER_EN
        pend_shape_d   = pend_shape_q;
        pend_color_d   = pend_color_q;
        pend_full_d    = pend_full_q;
        // Commit and accept are exclusive: accept needs an empty slot, commit a full one.
        if (frame_sync && pend_full_q) begin
            active_shape_d = pend_shape_q;
            active_color_d = pend_color_q;
            pend_full_d    = 1'b0;
        end
        if (load_valid && load_ready) begin
            pend_shape_d = shape_in;
            pend_color_d = color_in;
            pend_full_d  = 1'b1;
        end
`else
        if (load_valid) begin
            active_shape_d = shape_in;
            active_color_d = color_in;
        end
`endif
        if (frame_sync) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end

        is_grid_d     = in_box & on_line;
        is_block_d    = interior && active_shape_q[cell_idx] && !(blink_en && blink_phase_q);
        block_color_d = is_block_d ? active_color_q : 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the shape registers are cleared too, so a reset box renders empty.
            active_shape_q <= '0;
            active_color_q <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            is_grid_q      <= 1'b0;
            is_block_q     <= 1'b0;
            block_color_q  <= '0;
`ifdef PREVIEW_DOUBLE_BUFFER_EN
            pend_shape_q   <= '0;
            pend_color_q   <= '0;
            pend_full_q    <= 1'b0;
`endif
        end else begin
            active_shape_q <= active_shape_d;
            active_color_q <= active_color_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            is_grid_q      <= is_grid_d;
            is_block_q     <= is_block_d;
            block_color_q  <= block_color_d;
`ifdef PREVIEW_DOUBLE_BUFFER_EN
            pend_shape_q   <= pend_shape_d;
            pend_color_q   <= pend_color_d;
            pend_full_q    <= pend_full_d;
`endif
        end
    end

    assign is_grid     = is_grid_q;
    assign is_block    = is_block_q;
    assign block_color = block_color_q;

endmodule

// File: tb/tb_preview_box_mapper.sv
// Scoreboard bench for preview_box_mapper; follows PREVIEW_DOUBLE_BUFFER_EN like the design.
module tb_preview_box_mapper;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        frame_sync = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [11:0] shape_in = '0;
    logic [3:0]  color_in = '0;
    logic        blink_en = 1'b0;
    logic        is_grid;
    logic        is_block;
    logic [3:0]  block_color;

    typedef struct packed {
        logic       g;
        logic       b;
        logic [3:0] c;
    } pix_t;

    pix_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    fc       = 0;   // frame_syncs since the last reset

    preview_box_mapper dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_sync  (frame_sync),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .shape_in    (shape_in),
        .color_in    (color_in),
        .blink_en    (blink_en),
        .is_grid     (is_grid),
        .is_block    (is_block),
        .block_color (block_color)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    // Queue the expected outputs for the pixel being driven this cycle.
    task automatic expect_pix(input int x, input int y, input logic g, input logic b,
                              input logic [3:0] c, input string nm);
        DrawX = 10'(x);
        DrawY = 10'(y);
        exp_q.push_back('{g: g, b: b, c: c});
        name_q.push_back(nm);
    endtask

    // One clock edge; outputs are read 1 time unit after it and matched against the scoreboard.
    task automatic tick();
        pix_t  e;
        string nm;
        @(posedge Clk);
        #1;
        if (Reset) fc = 0;
        else if (frame_sync) fc++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ({is_grid, is_block, block_color} !== {e.g, e.b, e.c})
                $display("FAIL %s (x=%0d y=%0d): got grid=%b block=%b color=%0d, expected grid=%b block=%b color=%0d",
                         nm, DrawX, DrawY, is_grid, is_block, block_color, e.g, e.b, e.c);
            else
                n_pass++;
        end
    endtask

    function automatic pix_t model_pix(input int x, input int y, input logic [11:0] sh,
                                       input logic [3:0] c);
        pix_t r = '0;
        int dx = x - 140;
        int dy = y - 100;
        if (dx >= 0 && dx <= 80 && dy >= 0 && dy <= 60) begin
            if (dx % 20 == 0 || dy % 20 == 0) r.g = 1'b1;
            else if (sh[(dy / 20) * 4 + dx / 20]) begin
                r.b = 1'b1;
                r.c = c;
            end
        end
        return r;
    endfunction

    task automatic load_and_commit(input logic [11:0] sh, input logic [3:0] c);
        shape_in   = sh;
        color_in   = c;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
`ifdef PREVIEW_DOUBLE_BUFFER_EN
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
`endif
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        DrawX = 10'd140;
        DrawY = 10'd100;
        tick();
        tick();
        Reset = 1'b0;
        n_checks++;
        if ({is_grid, is_block, block_color} !== 6'b0)
            $display("FAIL reset outputs: got grid=%b block=%b color=%0d, expected all 0",
                     is_grid, is_block, block_color);
        else n_pass++;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL reset load_ready: got %b expected 1", load_ready);
        else n_pass++;
        expect_pix(140, 100, 1'b1, 1'b0, 4'd0, "top-left corner grid");        tick();
        expect_pix(221, 130, 1'b0, 1'b0, 4'd0, "right of box");                tick();
        expect_pix(220, 160, 1'b1, 1'b0, 4'd0, "bottom-right corner inclusive"); tick();
        expect_pix(139, 110, 1'b0, 1'b0, 4'd0, "left of box");                 tick();
        expect_pix(160, 105, 1'b1, 1'b0, 4'd0, "inner vertical line");         tick();
        expect_pix(150, 110, 1'b0, 1'b0, 4'd0, "empty interior");              tick();
    endtask

`ifdef PREVIEW_DOUBLE_BUFFER_EN
    task automatic test_load_commit();
        shape_in   = 12'h001;
        color_in   = 4'd5;
        load_valid = 1'b1;
        expect_pix(150, 110, 1'b0, 1'b0, 4'd0, "before load");
        tick();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) $display("FAIL ready after load: got %b expected 0", load_ready);
        else n_pass++;
        expect_pix(150, 110, 1'b0, 1'b0, 4'd0, "pending not visible");
        tick();
        frame_sync = 1'b1;
        expect_pix(155, 115, 1'b0, 1'b0, 4'd0, "commit edge shows old shape");
        tick();
        frame_sync = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL ready after commit: got %b expected 1", load_ready);
        else n_pass++;
        expect_pix(150, 110, 1'b0, 1'b1, 4'd5, "committed block"); tick();
    endtask

    task automatic test_overlap();
        // A accepted, B dropped while the slot is full.
        shape_in = 12'h002; color_in = 4'd6; load_valid = 1'b1; tick();
        shape_in = 12'h004; color_in = 4'd9; tick();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) $display("FAIL ready while full: got %b expected 0", load_ready);
        else n_pass++;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        expect_pix(170, 110, 1'b0, 1'b1, 4'd6, "A committed");    tick();
        expect_pix(190, 110, 1'b0, 1'b0, 4'd0, "B ignored");      tick();
        expect_pix(150, 110, 1'b0, 1'b0, 4'd0, "old cell gone");  tick();
        // Load and frame_sync together with an empty slot: commit waits a frame.
        shape_in = 12'h010; color_in = 4'd10; load_valid = 1'b1; frame_sync = 1'b1; tick();
        load_valid = 1'b0; frame_sync = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) $display("FAIL ready after load+sync: got %b expected 0", load_ready);
        else n_pass++;
        expect_pix(150, 130, 1'b0, 1'b0, 4'd0, "load+sync not committed"); tick();
        expect_pix(170, 110, 1'b0, 1'b1, 4'd6, "A still active");          tick();
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        expect_pix(150, 130, 1'b0, 1'b1, 4'd10, "committed next frame");   tick();
        // Load and frame_sync together with a full slot: commit wins, load dropped.
        shape_in = 12'h020; color_in = 4'd11; load_valid = 1'b1; tick();
        shape_in = 12'h040; color_in = 4'd12; frame_sync = 1'b1; tick();
        load_valid = 1'b0; frame_sync = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL ready after full commit: got %b expected 1", load_ready);
        else n_pass++;
        expect_pix(170, 130, 1'b0, 1'b1, 4'd11, "D1 committed"); tick();
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        expect_pix(190, 130, 1'b0, 1'b0, 4'd0, "D2 rejected");   tick();
        expect_pix(170, 130, 1'b0, 1'b1, 4'd11, "D1 held");      tick();
    endtask
`else
    task automatic test_direct_load();
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL ready before load: got %b expected 1", load_ready);
        else n_pass++;
        shape_in   = 12'h001;
        color_in   = 4'd3;
        load_valid = 1'b1;
        expect_pix(150, 110, 1'b0, 1'b0, 4'd0, "load edge shows old shape");
        tick();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL ready after load: got %b expected 1", load_ready);
        else n_pass++;
        expect_pix(150, 110, 1'b0, 1'b1, 4'd3, "direct load visible"); tick();
    endtask
`endif

    task automatic test_back_to_back();
        pix_t r;
        int   xs[6] = '{220, 140, 220, 221, 140, 200};
        int   ys[6] = '{160, 160, 100, 100, 161, 125};
        load_and_commit(12'hA5C, 4'hC);
        for (int i = 0; i < 6; i++) begin
            r = model_pix(xs[i], ys[i], 12'hA5C, 4'hC);
            expect_pix(xs[i], ys[i], r.g, r.b, r.c, "edge point");
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            int x = int'($urandom_range(230, 130));
            int y = int'($urandom_range(170, 90));
            r = model_pix(x, y, 12'hA5C, 4'hC);
            expect_pix(x, y, r.g, r.b, r.c, "sweep");
            tick();
        end
    endtask

    task automatic test_blink();
        logic vis;
        Reset = 1'b1; tick(); Reset = 1'b0;
        blink_en = 1'b1;
        load_and_commit(12'h800, 4'd7);
        expect_pix(210, 150, 1'b0, 1'b1, 4'd7, "blink start visible"); tick();
        while (fc < 62) begin
            frame_sync = 1'b1; tick(); frame_sync = 1'b0;
            vis = ((fc / 30) % 2) == 0;
            expect_pix(210, 150, 1'b0, vis, vis ? 4'd7 : 4'd0, $sformatf("blink frame %0d", fc));
            tick();
            if (fc == 45) begin
                blink_en = 1'b0;
                expect_pix(210, 150, 1'b0, 1'b1, 4'd7, "blink_en cleared shows block"); tick();
                blink_en = 1'b1;
            end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        shape_in = 12'h080; color_in = 4'd13; load_valid = 1'b1; tick(); load_valid = 1'b0;
`ifdef PREVIEW_DOUBLE_BUFFER_EN
        n_checks++;
        if (load_ready !== 1'b0) $display("FAIL ready before mid reset: got %b expected 0", load_ready);
        else n_pass++;
`else
        expect_pix(210, 130, 1'b0, 1'b1, 4'd13, "loaded before mid reset"); tick();
`endif
        Reset = 1'b1;
        expect_pix(140, 100, 1'b0, 1'b0, 4'd0, "outputs cleared by reset");
        tick();
        Reset = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL ready after mid reset: got %b expected 1", load_ready);
        else n_pass++;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        expect_pix(210, 130, 1'b0, 1'b0, 4'd0, "pending discarded");   tick();
        expect_pix(150, 110, 1'b0, 1'b0, 4'd0, "box empty after reset"); tick();
        expect_pix(140, 100, 1'b1, 1'b0, 4'd0, "grid after reset");     tick();
    endtask

    initial begin
        test_reset();
`ifdef PREVIEW_DOUBLE_BUFFER_EN
        test_load_commit();
        test_overlap();
`else
        test_direct_load();
`endif
        test_back_to_back();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
